hctrl_scanner: RTL and testbench



---
 rtl/hctrl_scanner.sv | 214 +++++++++++++++++++++
 tb/tb_hctrl_scanner.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hctrl_scanner.sv
// hctrl_scanner: LOAD#/serial-clock sequencer for the hand-controller shift-register chain.
// Optional build macro HCTRL_DEBOUNCE_EN: publish only when two consecutive raw scans agree.
module hctrl_scanner #(
    parameter int unsigned CLKDIV        = 128,
    parameter int unsigned NBITS         = 16,
    parameter int unsigned SCAN_INTERVAL = 65536
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scan_req,
    output logic       hctrl_clk,
    output logic       hctrl_load_n,
    input  logic       hctrl_data,
    output logic [7:0] hctrl1_data,
    output logic [7:0] hctrl2_data,
    output logic       data_valid,
    output logic       busy,
    output logic       irq,
    input  logic       irq_ack
);

    localparam int unsigned SR_W  = 16;
    localparam int unsigned PH_W  = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam int unsigned BIT_W = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam int unsigned INT_W = (SCAN_INTERVAL > 1) ? $clog2(SCAN_INTERVAL) : 1;

    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(CLKDIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NBITS - 1);
    localparam logic [INT_W-1:0] INT_LAST = INT_W'(SCAN_INTERVAL - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_SHIFT_LO = 3'd2,
        S_SHIFT_HI = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [PH_W-1:0]    r_ph;
    logic [BIT_W-1:0]   r_bit;
    logic [INT_W-1:0]   r_int;
    logic               r_pending;
    logic [SR_W-1:0]    r_data;

    logic               r_hctrl_clk;
    logic               r_hctrl_load_n;
    logic               r_busy;
    logic               r_data_valid;
    logic               r_irq;
    logic [7:0]         r_hctrl1_data;
    logic [7:0]         r_hctrl2_data;

    logic               w_ph_last;
    logic               w_bit_last;
    logic               w_int_last;
    logic               w_clk_nxt;
    logic               w_load_n_nxt;
    logic               w_busy_nxt;
    logic               w_publish;
    logic               w_irq_set;

    assign w_ph_last  = (r_ph == PH_LAST);
    assign w_bit_last = (r_bit == BIT_LAST);
    assign w_int_last = (r_int == INT_LAST);

`ifdef HCTRL_DEBOUNCE_EN
    logic [SR_W-1:0]    r_shadow;

    // Previous raw scan; a result is trusted only when it repeats.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shadow <= 16'hFFFF;
        end else if (r_state == S_DONE) begin
            r_shadow <= r_data;
        end
    end

    assign w_publish = (r_state == S_DONE) && (r_data == r_shadow);
`else
    assign w_publish = (r_state == S_DONE);
`endif

    assign w_irq_set = w_publish && (r_data != {r_hctrl2_data, r_hctrl1_data});

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_int_last || scan_req || r_pending) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_ph_last) begin
                    w_state_nxt = S_SHIFT_LO;
                end
            end
            S_SHIFT_LO: begin
                if (w_ph_last) begin
                    w_state_nxt = w_bit_last ? S_DONE : S_SHIFT_HI;
                end
            end
            S_SHIFT_HI: begin
                if (w_ph_last) begin
                    w_state_nxt = S_SHIFT_LO;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Pin/status values for the coming state, registered below so they line up with it
    always_comb begin
        w_clk_nxt    = 1'b0;
        w_load_n_nxt = 1'b1;
        w_busy_nxt   = 1'b1;
        case (w_state_nxt)
            S_IDLE:     w_busy_nxt   = 1'b0;
            S_LOAD:     w_load_n_nxt = 1'b0;
            S_SHIFT_HI: w_clk_nxt    = 1'b1;
            default:    w_busy_nxt   = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hctrl_clk    <= 1'b0;
            r_hctrl_load_n <= 1'b1;
            r_busy         <= 1'b0;
            r_ph           <= '0;
            r_bit          <= '0;
            r_int          <= '0;
            r_pending      <= 1'b0;
            r_data         <= 16'hFFFF;
            r_data_valid   <= 1'b0;
            r_irq          <= 1'b0;
            r_hctrl1_data  <= 8'hFF;
            r_hctrl2_data  <= 8'hFF;
        end else begin
            r_hctrl_clk    <= w_clk_nxt;
            r_hctrl_load_n <= w_load_n_nxt;
            r_busy         <= w_busy_nxt;
            r_data_valid   <= w_publish;

            // Phase restarts on every state change; idle keeps it parked at zero
            if ((w_state_nxt == r_state) && (r_state != S_IDLE)) begin
                r_ph <= r_ph + PH_W'(1);
            end else begin
                r_ph <= '0;
            end

            if ((r_state == S_LOAD) || (r_state == S_DONE)) begin
                r_bit <= '0;
            end else if ((r_state == S_SHIFT_HI) && w_ph_last) begin
                r_bit <= r_bit + BIT_W'(1);
            end

            if ((r_state == S_IDLE) && (w_state_nxt == S_IDLE)) begin
                r_int <= r_int + INT_W'(1);
            end else begin
                r_int <= '0;
            end

            // One-deep request memory; extra requests during a scan merge
            if ((r_state != S_IDLE) && scan_req) begin
                r_pending <= 1'b1;
            end else if ((r_state == S_IDLE) && (w_state_nxt == S_LOAD)) begin
                r_pending <= 1'b0;
            end

            if ((r_state == S_SHIFT_LO) && w_ph_last) begin
                r_data <= {r_data[SR_W-2:0], hctrl_data};
            end

            if (w_publish) begin
                r_hctrl2_data <= r_data[15:8];
                r_hctrl1_data <= r_data[7:0];
            end

            if (w_irq_set) begin
                r_irq <= 1'b1;
            end else if (irq_ack) begin
                r_irq <= 1'b0;
            end
        end
    end

    assign hctrl_clk    = r_hctrl_clk;
    assign hctrl_load_n = r_hctrl_load_n;
    assign busy         = r_busy;
    assign data_valid   = r_data_valid;
    assign irq          = r_irq;
    assign hctrl1_data  = r_hctrl1_data;
    assign hctrl2_data  = r_hctrl2_data;

endmodule

// File: tb/tb_hctrl_scanner.sv
// Bench for hctrl_scanner: chain model, vector table of scans, scoreboard on data_valid.
`timescale 1ns/1ps
module tb_hctrl_scanner;

    localparam int unsigned CLKDIV        = 4;
    localparam int unsigned SCAN_INTERVAL = 256;
    localparam int          DONE_IDX      = CLKDIV * 32;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scan_req = 1'b0;
    logic       irq_ack = 1'b0;
    logic       hctrl_clk;
    logic       hctrl_load_n;
    logic       hctrl_data;
    logic [7:0] hctrl1_data;
    logic [7:0] hctrl2_data;
    logic       data_valid;
    logic       busy;
    logic       irq;

    hctrl_scanner #(
        .CLKDIV        (CLKDIV),
        .NBITS         (16),
        .SCAN_INTERVAL (SCAN_INTERVAL)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .scan_req     (scan_req),
        .hctrl_clk    (hctrl_clk),
        .hctrl_load_n (hctrl_load_n),
        .hctrl_data   (hctrl_data),
        .hctrl1_data  (hctrl1_data),
        .hctrl2_data  (hctrl2_data),
        .data_valid   (data_valid),
        .busy         (busy),
        .irq          (irq),
        .irq_ack      (irq_ack)
    );

    always #5 clk = ~clk;

    // Parallel-load/serial-out chain: loads while LOAD# low, shifts on hctrl_clk rise
    logic [15:0] chain_pat = 16'hFFFF;
    logic [15:0] chain_sr  = 16'hFFFF;
    logic        chain_prev_clk = 1'b0;
    always @(negedge clk) begin
        if (!hctrl_load_n) chain_sr = chain_pat;
        else if (hctrl_clk && !chain_prev_clk) chain_sr = {chain_sr[14:0], 1'b1};
        chain_prev_clk = hctrl_clk;
    end
    assign hctrl_data = chain_sr[15];

    typedef struct packed {
        logic [7:0] h2;
        logic [7:0] h1;
        logic       irq;
    } exp_t;

    typedef struct {
        logic [15:0] pat;
        bit          ack_before;
        bit          ack_at_done;
        logic [7:0]  h2;
        logic [7:0]  h1;
        logic        irq;
    } vec_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every data_valid must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (data_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_data_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("hctrl2_data", 32'(hctrl2_data), 32'(e.h2));
                check("hctrl1_data", 32'(hctrl1_data), 32'(e.h1));
                check("irq", 32'(irq), 32'(e.irq));
            end
        end
    end

    // Issue one scan_req and follow the scan until its data_valid slot
    task automatic run_scan(input logic [15:0] pat, input bit pub, input exp_t e,
                            input bit ack_done, input bit chk_timing);
        int  low_cycles = 0;
        int  rises = 0;
        int  dv_idx = -1;
        bit  seen_busy = 0;
        bit  done = 0;
        logic prev;
        chain_pat = pat;
        if (pub) sb_q.push_back(e);
        scan_req = 1'b1;
        @(negedge clk);
        scan_req = 1'b0;
        prev = hctrl_clk;
        for (int i = 0; i < 400; i++) begin
            if (!hctrl_load_n) low_cycles++;
            if (hctrl_clk && !prev) rises++;
            prev = hctrl_clk;
            if (busy) seen_busy = 1;
            else if (seen_busy) begin
                dv_idx = i;
                done = 1;
            end
            if (done) break;
            irq_ack = (ack_done && i == DONE_IDX);
            @(negedge clk);
        end
        irq_ack = 1'b0;
        check("scan_completes", 32'(done), 32'd1);
        if (chk_timing) begin
            check("load_n_low_cycles", 32'(low_cycles), 32'(CLKDIV));
            check("hctrl_clk_rises", 32'(rises), 32'd15);
            check("scan_latency", 32'(dv_idx), 32'(DONE_IDX + 1));
        end
    endtask

    task automatic wait_idle(input int budget);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1;
                break;
            end
        end
        check("wait_idle", 32'(ok), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[8];
        logic [15:0] prev_raw;
        int          fall;
        bit          seen_load;
        exp_t        e;

        vecs[0] = '{16'hA55A, 0, 0, 8'hA5, 8'h5A, 1'b1};
        vecs[1] = '{16'hA55A, 0, 0, 8'hA5, 8'h5A, 1'b1};
        vecs[2] = '{16'hA55A, 1, 0, 8'hA5, 8'h5A, 1'b0};
        vecs[3] = '{16'hA45A, 0, 0, 8'hA4, 8'h5A, 1'b1};
        vecs[4] = '{16'hA45A, 1, 0, 8'hA4, 8'h5A, 1'b0};
        vecs[5] = '{16'h0000, 0, 1, 8'h00, 8'h00, 1'b1};
        vecs[6] = '{16'h0000, 1, 0, 8'h00, 8'h00, 1'b0};
        vecs[7] = '{16'hFFFF, 0, 0, 8'hFF, 8'hFF, 1'b1};

        // Reset state and first automatic scan
        repeat (3) @(negedge clk);
        check("rst_h1", 32'(hctrl1_data), 32'hFF);
        check("rst_h2", 32'(hctrl2_data), 32'hFF);
        check("rst_load_n", 32'(hctrl_load_n), 32'd1);
        check("rst_hclk", 32'(hctrl_clk), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        reset = 1'b0;
        fall = -1;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            if (!hctrl_load_n) begin
                fall = i;
                break;
            end
        end
        check("first_auto_load", 32'(fall), 32'(SCAN_INTERVAL));
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Vector table
        prev_raw = 16'hFFFF;
        for (int k = 0; k < 8; k++) begin
            e = '{h2: vecs[k].h2, h1: vecs[k].h1, irq: vecs[k].irq};
            if (vecs[k].ack_before) begin
                irq_ack = 1'b1;
                @(negedge clk);
                irq_ack = 1'b0;
                check("irq_after_ack", 32'(irq), 32'd0);
            end
`ifdef HCTRL_DEBOUNCE_EN
            run_scan(vecs[k].pat, vecs[k].pat == prev_raw, e, 1'b0, 1'b0);
`endif
            run_scan(vecs[k].pat, 1'b1, e, vecs[k].ack_at_done, k == 0);
            prev_raw = vecs[k].pat;
            @(negedge clk);
        end

        // Three requests during a scan merge into one follow-up scan
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        chain_pat = 16'h3C3C;
        e = '{h2: 8'h3C, h1: 8'h3C, irq: 1'b1};
`ifndef HCTRL_DEBOUNCE_EN
        sb_q.push_back(e);
`endif
        sb_q.push_back(e);
        scan_req = 1'b1;
        @(negedge clk);
        scan_req = 1'b0;
        for (int i = 1; i < 300; i++) begin
            scan_req = (i == 10 || i == 40 || i == 100);
            @(negedge clk);
            if (!busy) break;
        end
        scan_req = 1'b0;
        check("pend_dv_load_n", 32'(hctrl_load_n), 32'd1);
        @(negedge clk);
        check("pend_restart_load_n", 32'(hctrl_load_n), 32'd0);
        wait_idle(300);
        seen_load = 0;
        repeat (30) begin
            @(negedge clk);
            if (!hctrl_load_n || busy) seen_load = 1;
        end
        check("no_third_scan", 32'(seen_load), 32'd0);

        // Reset during SHIFT_HI
        chain_pat = 16'h0F0F;
        scan_req = 1'b1;
        @(negedge clk);
        scan_req = 1'b0;
        seen_load = 0;
        for (int i = 0; i < 100; i++) begin
            if (hctrl_clk) begin
                seen_load = 1;
                break;
            end
            @(negedge clk);
        end
        check("reached_shift_hi", 32'(seen_load), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_hclk", 32'(hctrl_clk), 32'd0);
        check("mid_rst_load_n", 32'(hctrl_load_n), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_h1", 32'(hctrl1_data), 32'hFF);
        check("mid_rst_h2", 32'(hctrl2_data), 32'hFF);
        check("mid_rst_dv", 32'(data_valid), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Changing then repeated raw scans
`ifdef HCTRL_DEBOUNCE_EN
        run_scan(16'h1234, 1'b0, '{h2: 8'h12, h1: 8'h34, irq: 1'b1}, 1'b0, 1'b0);
        run_scan(16'h1235, 1'b0, '{h2: 8'h12, h1: 8'h35, irq: 1'b1}, 1'b0, 1'b0);
        check("debounce_hold_h1", 32'(hctrl1_data), 32'hFF);
`else
        run_scan(16'h1234, 1'b1, '{h2: 8'h12, h1: 8'h34, irq: 1'b1}, 1'b0, 1'b0);
        run_scan(16'h1235, 1'b1, '{h2: 8'h12, h1: 8'h35, irq: 1'b1}, 1'b0, 1'b0);
`endif
        run_scan(16'h1235, 1'b1, '{h2: 8'h12, h1: 8'h35, irq: 1'b1}, 1'b0, 1'b0);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
